// File: rtl/fetch_controller_pkg.sv
// Shared IF-stage definitions: word width, NOP encoding, fetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_controller_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // ADDI x0, x0, 0
    localparam word_t NOP_ENC = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at fetch_pc
        HOLD  = 2'd1,   // word parked in the pending buffer, waiting for STALL to drop
        FLUSH = 2'd2    // request outstanding but its data is already dead
    } fetch_state_t;

    // Instruction addresses are word aligned; low bits of a redirect are ignored.
    function automatic word_t align_word(input word_t addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pending_buf.sv
// One-entry holding register for a word that completed while the pipeline was stalled.
// Latency: load/clear take effect on the next clock edge; contents visible the cycle after.
// Backpressure: none of its own; clear wins over load when both are asserted.
//
// Ports: clk/rst (async active-high), load + load_pc/load_instr to capture,
//        clear to drop the entry, buf_vld/buf_pc/buf_instr for the held word.
module fetch_pending_buf
    import fetch_controller_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  word_t load_pc,
    input  word_t load_instr,
    output logic  buf_vld,
    output word_t buf_pc,
    output word_t buf_instr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_vld   <= 1'b0;
            buf_pc    <= '0;
            buf_instr <= NOP_ENC;
        end else if (clear) begin
            buf_vld   <= 1'b0;
        end else if (load) begin
            buf_vld   <= 1'b1;
            buf_pc    <= load_pc;
            buf_instr <= load_instr;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns fetch PC, issues one instruction read at a time, feeds IF/ID.
// Latency: word presented on PC/INSTRUCTION the edge its MEM_READ & ~MEM_BUSYWAIT cycle ends.
// Backpressure: STALL holds outputs and parks a completed word; MEM_BUSYWAIT inserts NOP bubbles.
//
// Ports: CLK, RESET (async active-high); STALL from hazard unit; BRANCH_TAKEN/BRANCH_TARGET
//        redirect from EX; MEM_READ/MEM_ADDRESS/MEM_BUSYWAIT/MEM_READDATA to instruction
//        memory; PC/INSTRUCTION/INSTR_VALID registered outputs to IF/ID.
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        MEM_READ,
    output logic [31:0] MEM_ADDRESS,
    input  logic        MEM_BUSYWAIT,
    input  logic [31:0] MEM_READDATA,
    output logic [31:0] PC,
    output logic [31:0] INSTRUCTION,
    output logic        INSTR_VALID
);

    fetch_state_t state_q;
    word_t        fetch_pc_q;
    word_t        redirect_pc_q;   // target remembered while a dead request drains
    word_t        pc_q;
    word_t        instr_q;
    logic         valid_q;

    logic         done;
    word_t        branch_pc;
    logic         pend_load;
    logic         pend_clear;
    logic         pend_vld;
    word_t        pend_pc;
    word_t        pend_instr;

    // A request is never issued in HOLD, and RESET kills it combinationally so
    // memory sees the request vanish the instant reset rises.
    assign MEM_READ    = ~RESET & (state_q != HOLD);
    assign MEM_ADDRESS = fetch_pc_q;
    assign done        = MEM_READ & ~MEM_BUSYWAIT;
    assign branch_pc   = align_word(BRANCH_TARGET);

    assign PC          = pc_q;
    assign INSTRUCTION = instr_q;
    assign INSTR_VALID = valid_q;

    // Park only a live word that finished under STALL; a redirect that same
    // cycle makes the word dead, so it is never captured.
    assign pend_load  = (state_q == FETCH) & done & STALL & ~BRANCH_TAKEN;
    assign pend_clear = (state_q == HOLD) & (BRANCH_TAKEN | ~STALL);

    fetch_pending_buf u_pending_buf (
        .clk        (CLK),
        .rst        (RESET),
        .load       (pend_load),
        .clear      (pend_clear),
        .load_pc    (fetch_pc_q),
        .load_instr (MEM_READDATA),
        .buf_vld    (pend_vld),
        .buf_pc     (pend_pc),
        .buf_instr  (pend_instr)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= FETCH;
            fetch_pc_q    <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (BRANCH_TAKEN) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                        if (done) begin
                            // Request just finished, so the new target can go out next cycle.
                            fetch_pc_q <= branch_pc;
                        end else begin
                            // Memory still owes us a word; let it drain before redirecting.
                            redirect_pc_q <= branch_pc;
                            state_q       <= FLUSH;
                        end
                    end else if (STALL) begin
                        // Outputs hold; a finished word moves into the pending buffer.
                        if (done) begin
                            state_q <= HOLD;
                        end
                    end else if (done) begin
                        pc_q       <= fetch_pc_q;
                        instr_q    <= MEM_READDATA;
                        valid_q    <= 1'b1;
                        fetch_pc_q <= fetch_pc_q + 32'd4;
                    end else begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end

                HOLD: begin
                    if (BRANCH_TAKEN) begin
                        instr_q    <= NOP_INSTR;
                        valid_q    <= 1'b0;
                        fetch_pc_q <= branch_pc;
                        state_q    <= FETCH;
                    end else if (!STALL) begin
                        pc_q       <= pend_pc;
                        instr_q    <= pend_instr;
                        valid_q    <= pend_vld;
                        fetch_pc_q <= pend_pc + 32'd4;
                        state_q    <= FETCH;
                    end
                end

                FLUSH: begin
                    // Nothing useful can reach IF/ID until the dead request drains.
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (BRANCH_TAKEN) begin
                        if (done) begin
                            fetch_pc_q <= branch_pc;
                            state_q    <= FETCH;
                        end else begin
                            redirect_pc_q <= branch_pc;
                        end
                    end else if (done) begin
                        fetch_pc_q <= redirect_pc_q;
                        state_q    <= FETCH;
                    end
                end

                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed stimulus, memory with programmable wait states,
// and a transaction-level model (next address, parked word, dead request) checked every cycle.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        MEM_READ;
    logic [31:0] MEM_ADDRESS;
    logic        MEM_BUSYWAIT;
    logic [31:0] MEM_READDATA;
    logic [31:0] PC;
    logic [31:0] INSTRUCTION;
    logic        INSTR_VALID;

    int checks = 0;
    int errors = 0;
    int wait_cycles = 0;
    int wcnt = 0;

    always #5 CLK = ~CLK;

    fetch_controller #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .MEM_READ      (MEM_READ),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .MEM_READDATA  (MEM_READDATA),
        .PC            (PC),
        .INSTRUCTION   (INSTRUCTION),
        .INSTR_VALID   (INSTR_VALID)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hDEAD_0000 | {16'h0000, a[15:0]};
    endfunction

    // Memory: answers any address, busy for wait_cycles cycles at the start of each access.
    assign MEM_READDATA = word_at(MEM_ADDRESS);
    assign MEM_BUSYWAIT = (wcnt < wait_cycles);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- model ----------------
    // m_addr: address the fetcher is currently asking for (or will ask for).
    // m_parked: a finished word is waiting for STALL to fall (no request meanwhile).
    // m_doomed: the outstanding request's data must be thrown away; go to m_redirect after.
    logic [31:0] m_addr, m_redirect, m_park_pc, m_park_word, m_pc, m_instr;
    logic        m_parked, m_doomed, m_valid;

    logic [31:0] n_addr, n_redirect, n_park_pc, n_park_word, n_pc, n_instr, n_tgt;
    logic        n_parked, n_doomed, n_valid, n_rd, n_busy, n_done;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_addr      <= 32'h0;
            m_redirect  <= 32'h0;
            m_park_pc   <= 32'h0;
            m_park_word <= 32'h0;
            m_pc        <= 32'h0;
            m_instr     <= NOP;
            m_parked    <= 1'b0;
            m_doomed    <= 1'b0;
            m_valid     <= 1'b0;
            wcnt        <= 0;
        end else begin
            n_addr = m_addr; n_redirect = m_redirect; n_park_pc = m_park_pc;
            n_park_word = m_park_word; n_pc = m_pc; n_instr = m_instr;
            n_parked = m_parked; n_doomed = m_doomed; n_valid = m_valid;
            n_rd   = !m_parked;
            n_busy = (wcnt < wait_cycles);
            n_done = n_rd && !n_busy;
            n_tgt  = BRANCH_TARGET & 32'hFFFF_FFFC;
            if (BRANCH_TAKEN) begin
                n_valid = 1'b0; n_instr = NOP;
                if (m_parked) begin
                    n_parked = 1'b0; n_addr = n_tgt;
                end else if (n_done) begin
                    n_doomed = 1'b0; n_addr = n_tgt;
                end else begin
                    n_doomed = 1'b1; n_redirect = n_tgt;
                end
            end else if (m_doomed) begin
                n_valid = 1'b0; n_instr = NOP;
                if (n_done) begin
                    n_doomed = 1'b0; n_addr = m_redirect;
                end
            end else if (m_parked) begin
                if (!STALL) begin
                    n_valid = 1'b1; n_pc = m_park_pc; n_instr = m_park_word;
                    n_addr = m_park_pc + 32'd4; n_parked = 1'b0;
                end
            end else if (STALL) begin
                if (n_done) begin
                    n_parked = 1'b1; n_park_pc = m_addr; n_park_word = word_at(m_addr);
                end
            end else if (n_done) begin
                n_valid = 1'b1; n_pc = m_addr; n_instr = word_at(m_addr);
                n_addr = m_addr + 32'd4;
            end else begin
                n_valid = 1'b0; n_instr = NOP;
            end
            m_addr <= n_addr; m_redirect <= n_redirect; m_park_pc <= n_park_pc;
            m_park_word <= n_park_word; m_pc <= n_pc; m_instr <= n_instr;
            m_parked <= n_parked; m_doomed <= n_doomed; m_valid <= n_valid;
            wcnt <= (n_rd && n_busy) ? wcnt + 1 : 0;
        end
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge CLK) begin
        if (RESET === 1'b0) begin
            chk("cyc_mem_read", {31'h0, MEM_READ}, {31'h0, !m_parked});
            chk("cyc_mem_address", MEM_ADDRESS, m_addr);
            chk("cyc_instr_valid", {31'h0, INSTR_VALID}, {31'h0, m_valid});
            chk("cyc_instruction", INSTRUCTION, m_instr);
            if (m_valid) chk("cyc_pc", PC, m_pc);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        STALL = 0; BRANCH_TAKEN = 0; BRANCH_TARGET = 32'h0; wait_cycles = 0; RESET = 0;
        #1 RESET = 1;
        tick(); tick();
        chk("rst_mem_read", {31'h0, MEM_READ}, 32'h0);
        chk("rst_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("rst_instr", INSTRUCTION, 32'h0000_0013);
        chk("rst_pc", PC, 32'h0);
        RESET = 0;
        #1;
        chk("first_addr", MEM_ADDRESS, 32'h0);
        chk("first_read", {31'h0, MEM_READ}, 32'h1);

        // zero-wait streaming
        tick(); chk("seq_pc0", PC, 32'h0); chk("seq_v0", {31'h0, INSTR_VALID}, 32'h1);
        chk("seq_i0", INSTRUCTION, 32'hDEAD_0000);
        chk("model_pin_pc0", m_pc, 32'h0);
        tick(); chk("seq_pc4", PC, 32'h4);
        tick(); chk("seq_pc8", PC, 32'h8);
        tick(); chk("seq_pcc", PC, 32'hC); chk("seq_addr10", MEM_ADDRESS, 32'h10);

        // stall three cycles at completion of 0x10
        STALL = 1;
        tick(); chk("stall_pc", PC, 32'hC); chk("stall_i", INSTRUCTION, 32'hDEAD_000C);
        chk("stall_noread", {31'h0, MEM_READ}, 32'h0);
        tick(); tick(); chk("stall_pc3", PC, 32'hC);
        STALL = 0;
        tick(); chk("unstall_pc", PC, 32'h10); chk("unstall_i", INSTRUCTION, 32'hDEAD_0010);
        chk("unstall_addr", MEM_ADDRESS, 32'h14);
        tick(); chk("after_pc14", PC, 32'h14);

        // two wait states per access
        wait_cycles = 2;
        tick(); chk("wait_v0", {31'h0, INSTR_VALID}, 32'h0); chk("wait_nop", INSTRUCTION, 32'h13);
        chk("wait_addr", MEM_ADDRESS, 32'h18);
        tick(); chk("wait_v1", {31'h0, INSTR_VALID}, 32'h0); chk("wait_addr2", MEM_ADDRESS, 32'h18);
        tick(); chk("wait_pc18", PC, 32'h18); chk("wait_v2", {31'h0, INSTR_VALID}, 32'h1);
        tick(); tick(); tick(); chk("wait_pc1c", PC, 32'h1C); chk("wait_addr20", MEM_ADDRESS, 32'h20);

        // redirect while 0x20 is still waiting
        BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h40;
        tick(); BRANCH_TAKEN = 0;
        chk("flush_v", {31'h0, INSTR_VALID}, 32'h0); chk("flush_addr", MEM_ADDRESS, 32'h20);
        chk("flush_read", {31'h0, MEM_READ}, 32'h1);
        tick(); chk("flush_addr2", MEM_ADDRESS, 32'h20);
        tick(); chk("flush_new_addr", MEM_ADDRESS, 32'h40); chk("flush_v2", {31'h0, INSTR_VALID}, 32'h0);
        wait_cycles = 0;
        tick(); chk("br_pc40", PC, 32'h40); chk("br_i40", INSTRUCTION, 32'hDEAD_0040);

        // redirect to unaligned target while parked under STALL
        STALL = 1;
        tick(); chk("hold_noread", {31'h0, MEM_READ}, 32'h0); chk("hold_pc", PC, 32'h40);
        BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h83;
        tick(); BRANCH_TAKEN = 0; STALL = 0;
        chk("hbr_v", {31'h0, INSTR_VALID}, 32'h0); chk("hbr_i", INSTRUCTION, 32'h13);
        chk("hbr_addr", MEM_ADDRESS, 32'h80); chk("hbr_read", {31'h0, MEM_READ}, 32'h1);
        tick(); chk("hbr_pc80", PC, 32'h80);

        // redirect on a completing fetch, then address wrap
        BRANCH_TAKEN = 1; BRANCH_TARGET = 32'hFFFF_FFFC;
        tick(); BRANCH_TAKEN = 0;
        chk("wrap_v", {31'h0, INSTR_VALID}, 32'h0); chk("wrap_addr", MEM_ADDRESS, 32'hFFFF_FFFC);
        tick(); chk("wrap_pc", PC, 32'hFFFF_FFFC); chk("wrap_next", MEM_ADDRESS, 32'h0);
        tick(); chk("wrap_pc0", PC, 32'h0);

        // second redirect overrides the first while draining, with STALL up
        wait_cycles = 2; STALL = 1;
        BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h100;
        tick(); chk("rt_v", {31'h0, INSTR_VALID}, 32'h0);
        BRANCH_TARGET = 32'h200;
        tick(); BRANCH_TAKEN = 0;
        chk("rt_nop", INSTRUCTION, 32'h13); chk("rt_addr", MEM_ADDRESS, 32'h4);
        tick(); chk("rt_new_addr", MEM_ADDRESS, 32'h200); chk("rt_v2", {31'h0, INSTR_VALID}, 32'h0);
        STALL = 0; wait_cycles = 0;
        tick(); chk("rt_pc200", PC, 32'h200);

        // reset in the middle of a wait at 0x1C
        BRANCH_TAKEN = 1; BRANCH_TARGET = 32'h1C;
        tick(); BRANCH_TAKEN = 0; chk("rw_addr", MEM_ADDRESS, 32'h1C);
        wait_cycles = 2;
        tick(); chk("rw_addr2", MEM_ADDRESS, 32'h1C); chk("rw_read", {31'h0, MEM_READ}, 32'h1);
        #2 RESET = 1;
        #1;
        chk("rw_read_drop", {31'h0, MEM_READ}, 32'h0);
        chk("rw_valid", {31'h0, INSTR_VALID}, 32'h0);
        chk("rw_instr", INSTRUCTION, 32'h13);
        tick(); tick();
        RESET = 0; wait_cycles = 0;
        #1;
        chk("rw_rel_addr", MEM_ADDRESS, 32'h0); chk("rw_rel_read", {31'h0, MEM_READ}, 32'h1);
        tick(); chk("rw_pc0", PC, 32'h0); chk("rw_v", {31'h0, INSTR_VALID}, 32'h1);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
